logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the fixed 32-bit bitwise gates.
- One block selects among eight bitwise operations through an opcode.
- Two register stages with valid/ready handshakes on both sides, result flags (zero, parity, all-ones) and a completed-operation counter.
- Sits in the ALU datapath between the operand fetch and writeback stages.

Parameters:
- WIDTH, 32, operand and result width in bits (≥1).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill; discards all in-flight operations.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block accepts the operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a, 111 NOT b.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- parity  out  1  XOR-reduction of result (1 = odd number of ones).
- all_ones  out  1  result == all ones.
- op_count  out  CNT_W  number of results consumed, modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous): v1, v2, out_valid = 0. Stage registers, result, zero, parity, all_ones, op_count = 0. While rst_n is low, in_ready = 0.
- Stage 1 (S1) register: a, b, op; valid bit v1.
- Stage 2 (S2) register: result and the three flags computed from S1; valid bit v2. out_valid = v2.
- Handshake:
  - s2_take = !v2 || out_ready.
  - in_ready = !flush && (!v1 || s2_take); combinational, never depends on in_valid.
  - An input is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
- Advance:
  - If v1 && s2_take: S2 loads the computed result and flags, and v2 ← 1.
  - Else if out_ready: v2 ← 0 (S2 drained, nothing to replace it).
  - If an input is accepted, S1 loads a, b, op and v1 ← 1. Otherwise, if v1 && s2_take, v1 ← 0.
- Latency and throughput: 2 cycles from acceptance to out_valid with no back-pressure; 1 operation per cycle sustained.
- Data stability: while out_valid && !out_ready, result and the flags hold stable. S1 also holds, so at most 2 operations are in flight.
- Flush:
  - The next edge clears v1 and v2.
  - Data registers keep their values, but the outputs are not valid.
  - op_count is unaffected by flush except for a consume in the same cycle, which still counts, because the downstream saw the handshake.
  - in_ready is 0 during a flush cycle, so no input is accepted.
- Flags are computed from the stage-2 combinational result and registered together with it. For WIDTH=1: zero = !result, all_ones = result, parity = result.
- op_count increments by 1 on each consume and wraps from 2^CNT_W−1 to 0.
- Opcode is fully decoded; no illegal codes exist.
- Reset asserted mid-operation: all in-flight operations are lost immediately (out_valid falls without waiting for clk). After release, the first acceptance is possible on the first edge.

Test Plan:
- WIDTH=32, out_ready=1:
  - a=0x33333333, b=0xCCCCCCCC, op=000 → 2 cycles later result=0x00000000, zero=1, parity=0, all_ones=0.
  - Same operands, op=001 → result=0xFFFFFFFF, all_ones=1, parity=0.
- Streaming one operation per cycle, all with a=0xFFFFFFFF, b=0xF0F0F0F0:
  - NAND → 0x0F0F0F0F, parity=0.
  - NOT b → 0x0F0F0F0F.
  - XOR → 0x0F0F0F0F.
  - Expect out_valid continuously high and op_count=3 after the last consume.
- Back-pressure: out_ready=0, present 3 operations (a=1, b=0, op=OR each) → the first two are accepted and in_ready falls. Result 0x00000001 (parity=1) is held stable. Raising out_ready drains all 3 in order, and op_count increments by 3.
- Flush with v1=v2=1 and out_ready=0 → next cycle out_valid=0, in_ready=1, op_count unchanged. A subsequent op (0x55555555 XNOR 0xAAAAAAAA) returns 0x00000000, zero=1.
- Drop rst_n between clock edges while out_valid=1 → out_valid=0 and op_count=0 immediately. After release, normal operation resumes.
- CNT_W=2: consume 5 results → op_count sequence 1,2,3,0,1 (wrap checked).

Source files
------------

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit.
// Stage 1 registers the operands and opcode, stage 2 registers the
// selected result together with its zero/parity/all-ones flags.
// Valid/ready handshakes on both sides; op_count tallies consumed results.
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             all_ones,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_NOTB = 3'b111;

    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic             s2_parity;
    logic             s2_all_ones;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] comb_result;
    logic             s2_take;
    logic             advance;
    logic             accept;
    logic             consume;

    // Stage 2 can take a new value when it is empty or being drained this cycle.
    assign s2_take   = !v2 || out_ready;
    assign advance   = v1 && s2_take;
    assign in_ready  = rst_n && !flush && (!v1 || s2_take);
    assign accept    = in_valid && in_ready;
    assign consume   = v2 && out_ready;

    assign out_valid = v2;
    assign result    = s2_result;
    assign zero      = s2_zero;
    assign parity    = s2_parity;
    assign all_ones  = s2_all_ones;
    assign op_count  = count;

    // Decode the stage-1 opcode into the bitwise result feeding stage 2.
    always_comb begin
        comb_result = '0;
        case (s1_op)
            OP_AND:  comb_result = s1_a & s1_b;
            OP_OR:   comb_result = s1_a | s1_b;
            OP_XOR:  comb_result = s1_a ^ s1_b;
            OP_NAND: comb_result = ~(s1_a & s1_b);
            OP_NOR:  comb_result = ~(s1_a | s1_b);
            OP_XNOR: comb_result = ~(s1_a ^ s1_b);
            OP_NOTA: comb_result = ~s1_a;
            OP_NOTB: comb_result = ~s1_b;
            default: comb_result = '0;
        endcase
    end

    // Valid bits: flush kills both stages, otherwise normal advance/drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (advance) begin
                v2 <= 1'b1;
            end else if (out_ready) begin
                v2 <= 1'b0;
            end
            if (accept) begin
                v1 <= 1'b1;
            end else if (advance) begin
                v1 <= 1'b0;
            end
        end
    end

    // Stage 1 data capture; in_ready already blocks capture during flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_op <= '0;
        end else if (accept) begin
            s1_a  <= a;
            s1_b  <= b;
            s1_op <= op;
        end
    end

    // Stage 2 result and flags load together; data holds across a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_result   <= '0;
            s2_zero     <= 1'b0;
            s2_parity   <= 1'b0;
            s2_all_ones <= 1'b0;
        end else if (advance && !flush) begin
            s2_result   <= comb_result;
            s2_zero     <= ~|comb_result;
            s2_parity   <= ^comb_result;
            s2_all_ones <= &comb_result;
        end
    end

    // Count consumed results; a consume during flush still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (consume) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe.
// Instance u_dut is 32 bits wide with a 16-bit counter; u_dut1 is 1 bit wide
// with a 2-bit counter to exercise the narrow-width flags and counter wrap.
module tb_logic_unit_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        parity;
    logic        all_ones;
    logic [15:0] op_count;

    logic        in_valid1;
    logic        in_ready1;
    logic        a1;
    logic        b1;
    logic [2:0]  op1;
    logic        out_valid1;
    logic        out_ready1;
    logic        result1;
    logic        zero1;
    logic        parity1;
    logic        all_ones1;
    logic [1:0]  op_count1;

    int checks;
    int errors;
    int expCount;

    logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .parity(parity), .all_ones(all_ones),
        .op_count(op_count)
    );

    logic_unit_pipe #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op(op1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .zero(zero1), .parity(parity1), .all_ones(all_ones1),
        .op_count(op_count1)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] va,
                                 input logic [31:0] vb, input logic [2:0] vop);
        in_valid = v;
        a        = va;
        b        = vb;
        op       = vop;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic [31:0] r,
                              input logic z, input logic p, input logic o);
        checkOutput({tag, " result"},   64'(result),   64'(r));
        checkOutput({tag, " zero"},     64'(zero),     64'(z));
        checkOutput({tag, " parity"},   64'(parity),   64'(p));
        checkOutput({tag, " all_ones"}, 64'(all_ones), 64'(o));
    endtask

    logic exp1 [5];

    initial begin
        checks    = 0;
        errors    = 0;
        expCount  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000);
        in_valid1  = 1'b0;
        a1         = 1'b0;
        b1         = 1'b0;
        op1        = 3'b000;
        out_ready1 = 1'b1;

        // Reset state
        #2;
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset in_ready",  64'(in_ready),  64'd0);
        checkOutput("reset op_count",  64'(op_count),  64'd0);
        checkOutput("reset result",    64'(result),    64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset in_ready", 64'(in_ready), 64'd1);

        // AND then OR of complementary patterns
        $display("[TB] basic AND/OR");
        applyStimulus(1'b1, 32'h33333333, 32'hCCCCCCCC, 3'b000);
        tick();
        checkOutput("and latency1 out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 32'h33333333, 32'hCCCCCCCC, 3'b001);
        tick();
        checkOutput("and out_valid", 64'(out_valid), 64'd1);
        checkFlags("and", 32'h00000000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        checkFlags("or", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        checkOutput("or op_count", 64'(op_count), 64'd1);
        tick();
        checkOutput("drain out_valid", 64'(out_valid), 64'd0);
        checkOutput("drain op_count",  64'(op_count),  64'd2);
        expCount = 2;

        // Streaming NAND, NOT b, XOR
        $display("[TB] streaming");
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'hF0F0F0F0, 3'b011);
        tick();
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'hF0F0F0F0, 3'b111);
        tick();
        checkOutput("stream in_ready", 64'(in_ready), 64'd1);
        checkOutput("stream nand valid", 64'(out_valid), 64'd1);
        checkFlags("stream nand", 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'hF0F0F0F0, 3'b010);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000);
        checkOutput("stream notb valid", 64'(out_valid), 64'd1);
        checkOutput("stream notb result", 64'(result), 64'h0F0F0F0F);
        tick();
        checkOutput("stream xor valid", 64'(out_valid), 64'd1);
        checkOutput("stream xor result", 64'(result), 64'h0F0F0F0F);
        tick();
        expCount += 3;
        checkOutput("stream op_count", 64'(op_count), 64'(expCount));
        checkOutput("stream end valid", 64'(out_valid), 64'd0);

        // Back-pressure: two accepted, third stalls
        $display("[TB] back-pressure");
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h1, 32'h0, 3'b001);
        #1;
        checkOutput("bp in_ready0", 64'(in_ready), 64'd1);
        tick();
        checkOutput("bp in_ready1", 64'(in_ready), 64'd1);
        tick();
        checkOutput("bp in_ready2", 64'(in_ready), 64'd0);
        checkOutput("bp out_valid", 64'(out_valid), 64'd1);
        checkFlags("bp", 32'h00000001, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("bp hold result", 64'(result), 64'h1);
            checkOutput("bp hold valid",  64'(out_valid), 64'd1);
            checkOutput("bp hold in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp hold op_count", 64'(op_count), 64'(expCount));
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp release in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            applyStimulus(1'b0, 32'h0, 32'h0, 3'b000);
            expCount++;
            checkOutput("bp drain op_count", 64'(op_count), 64'(expCount));
            checkOutput("bp drain valid", 64'(out_valid), (i < 2) ? 64'd1 : 64'd0);
        end

        // Flush with both stages full
        $display("[TB] flush");
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h1, 32'h0, 3'b001);
        tick();
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000);
        flush = 1'b1;
        #1;
        checkOutput("flush in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flush out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush in_ready after", 64'(in_ready), 64'd1);
        checkOutput("flush op_count", 64'(op_count), 64'(expCount));
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'h55555555, 32'hAAAAAAAA, 3'b101);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        checkOutput("xnor valid", 64'(out_valid), 64'd1);
        checkFlags("xnor", 32'h00000000, 1'b1, 1'b0, 1'b0);
        tick();
        expCount++;
        checkOutput("xnor op_count", 64'(op_count), 64'(expCount));

        // Flush while a consume happens in the same cycle
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h1, 32'h0, 3'b001);
        tick();
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        expCount++;
        checkOutput("flush+consume op_count", 64'(op_count), 64'(expCount));
        checkOutput("flush+consume valid", 64'(out_valid), 64'd0);
        tick();
        checkOutput("flush killed s1 valid", 64'(out_valid), 64'd0);
        checkOutput("flush killed s1 count", 64'(op_count), 64'(expCount));

        // Asynchronous reset between clock edges
        $display("[TB] async reset");
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 3'b000);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        checkOutput("pre-reset valid", 64'(out_valid), 64'd1);
        checkOutput("pre-reset result", 64'(result), 64'h0F0F0000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async out_valid", 64'(out_valid), 64'd0);
        checkOutput("async op_count", 64'(op_count), 64'd0);
        checkOutput("async in_ready", 64'(in_ready), 64'd0);
        checkOutput("async result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expCount = 0;
        #1;
        checkOutput("release in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        applyStimulus(1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 3'b000);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b000);
        tick();
        checkOutput("resume valid", 64'(out_valid), 64'd1);
        checkOutput("resume result", 64'(result), 64'h0F0F0000);
        tick();
        checkOutput("resume op_count", 64'(op_count), 64'd1);

        // One-bit datapath with a 2-bit counter: flags and wrap
        $display("[TB] width 1 / counter wrap");
        exp1[0] = 1'b0;
        exp1[1] = 1'b1;
        exp1[2] = 1'b1;
        exp1[3] = 1'b1;
        exp1[4] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            int consumed;
            if (i < 5) begin
                in_valid1 = 1'b1;
                a1        = 1'b1;
                b1        = 1'b0;
                op1       = 3'(i);
            end else begin
                in_valid1 = 1'b0;
            end
            tick();
            consumed = (i < 2) ? 0 : ((i - 1 > 5) ? 5 : i - 1);
            checkOutput("w1 op_count", 64'(op_count1), 64'(consumed % 4));
            if (i >= 1 && i <= 5) begin
                checkOutput("w1 valid",    64'(out_valid1), 64'd1);
                checkOutput("w1 result",   64'(result1),   64'(exp1[i-1]));
                checkOutput("w1 zero",     64'(zero1),     64'(!exp1[i-1]));
                checkOutput("w1 parity",   64'(parity1),   64'(exp1[i-1]));
                checkOutput("w1 all_ones", 64'(all_ones1), 64'(exp1[i-1]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
